// File: rtl/truth_table_checker.sv
// Response checker for a two-input gate driven through patterns 00,01,10,11.
// Samples inputs and output mid-phase, scores against EXP_TT, reports the verdict.
module truth_table_checker #(
  parameter int          PHASE_LEN = 250,
  parameter logic [3:0]  EXP_TT    = 4'b1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in0,
  input  logic       in1,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic       first_err_valid,
  output logic [1:0] first_err_idx,
  output logic       seq_err
);

  localparam logic [15:0] CNT_LAST = 16'(PHASE_LEN - 1);
  localparam logic [15:0] CNT_MID  = 16'(PHASE_LEN / 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [1:0]  r_idx;
  logic [2:0]  r_err_cnt;
  logic        r_first_err_valid;
  logic [1:0]  r_first_err_idx;
  logic        r_seq_err;

  logic        w_start_acc;
  logic        w_phase_end;
  logic        w_run_end;
  logic        w_sample;
  logic [1:0]  w_pat;
  logic        w_mismatch;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v >= 3'd4) ? 3'd4 : v + 3'd1;
  endfunction

  assign w_start_acc = start && (r_state != S_RUN);
  assign w_phase_end = (r_cnt == CNT_LAST);
  assign w_run_end   = (r_state == S_RUN) && w_phase_end && (r_idx == 2'd3);
  assign w_sample    = (r_state == S_RUN) && (r_cnt == CNT_MID);
  assign w_pat       = {in1, in0};
  // The expected value is looked up with the observed pattern, not the phase index.
  assign w_mismatch  = (dut_out != EXP_TT[w_pat]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)     w_next = S_RUN;
      S_RUN:   if (w_run_end) w_next = S_DONE;
      S_DONE:  if (start)     w_next = S_RUN;
      default:                w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt             <= '0;
      r_idx             <= '0;
      r_err_cnt         <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_idx   <= '0;
      r_seq_err         <= 1'b0;
    end else if (w_start_acc) begin
      r_cnt             <= '0;
      r_idx             <= '0;
      r_err_cnt         <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_idx   <= '0;
      r_seq_err         <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (w_phase_end) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_sample) begin
        if (w_pat != r_idx) r_seq_err <= 1'b1;
        if (w_mismatch) begin
          r_err_cnt <= sat_inc(r_err_cnt);
          if (!r_first_err_valid) begin
            r_first_err_valid <= 1'b1;
            r_first_err_idx   <= w_pat;
          end
        end
      end
    end
  end

  // Verdict outputs derive only from registers, so pass changes on the same edge as done.
  assign busy            = (r_state == S_RUN);
  assign done            = (r_state == S_DONE);
  assign pass            = done && (r_err_cnt == 3'd0) && !r_seq_err;
  assign err_cnt         = r_err_cnt;
  assign first_err_valid = r_first_err_valid;
  assign first_err_idx   = r_first_err_idx;
  assign seq_err         = r_seq_err;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed and randomized checks of truth_table_checker at PHASE_LEN 250, 8 and 2.
module tb_truth_table_checker;

  localparam logic [3:0] TT = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in0 = 1'b0, in1 = 1'b0, dut_out = 1'b0;
  logic [2:0] start_v = '0;
  logic [2:0] busy_w, done_w, pass_w, fev_w, seq_w;
  logic [8:0] err_w;
  logic [5:0] fei_w;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  truth_table_checker #(.PHASE_LEN(250), .EXP_TT(TT)) u_l250 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in0(in0), .in1(in1), .dut_out(dut_out),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_cnt(err_w[2:0]),
    .first_err_valid(fev_w[0]), .first_err_idx(fei_w[1:0]), .seq_err(seq_w[0]));

  truth_table_checker #(.PHASE_LEN(8), .EXP_TT(TT)) u_l8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in0(in0), .in1(in1), .dut_out(dut_out),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_cnt(err_w[5:3]),
    .first_err_valid(fev_w[1]), .first_err_idx(fei_w[3:2]), .seq_err(seq_w[1]));

  truth_table_checker #(.PHASE_LEN(2), .EXP_TT(TT)) u_l2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in0(in0), .in1(in1), .dut_out(dut_out),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_cnt(err_w[8:6]),
    .first_err_valid(fev_w[2]), .first_err_idx(fei_w[5:4]), .seq_err(seq_w[2]));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input int s, input string tag, input logic b, input logic d,
                         input logic p, input logic [2:0] e, input logic fv,
                         input logic [1:0] fi, input logic sq);
    chk({tag, ".busy"},  {7'd0, busy_w[s]}, {7'd0, b});
    chk({tag, ".done"},  {7'd0, done_w[s]}, {7'd0, d});
    chk({tag, ".pass"},  {7'd0, pass_w[s]}, {7'd0, p});
    chk({tag, ".err"},   {5'd0, err_w[3*s +: 3]}, {5'd0, e});
    chk({tag, ".fev"},   {7'd0, fev_w[s]}, {7'd0, fv});
    chk({tag, ".fei"},   {6'd0, fei_w[2*s +: 2]}, {6'd0, fi});
    chk({tag, ".seq"},   {7'd0, seq_w[s]}, {7'd0, sq});
  endtask

  // Scores one run from the list of presented patterns and observed outputs.
  task automatic model(input logic [7:0] pats, input logic [3:0] outs,
                       output logic [2:0] e, output logic fv, output logic [1:0] fi,
                       output logic sq);
    int bad [$];
    sq = 1'b0;
    for (int p = 0; p < 4; p++) begin
      logic [1:0] pat;
      pat = pats[2*p +: 2];
      if (int'(pat) != p) sq = 1'b1;
      if (outs[p] != TT[pat]) bad.push_back(int'(pat));
    end
    e  = 3'(bad.size() > 4 ? 4 : bad.size());
    fv = (bad.size() != 0);
    fi = fv ? 2'(bad[0]) : 2'd0;
  endtask

  function automatic logic [3:0] good_outs(input logic [7:0] pats);
    logic [3:0] o;
    for (int p = 0; p < 4; p++) o[p] = TT[pats[2*p +: 2]];
    return o;
  endfunction

  task automatic run(input string tag, input int s, input int L, input logic [7:0] pats,
                     input logic [3:0] outs, input bit mid_start, input int rst_at);
    logic [2:0] e;
    logic fv, sq;
    logic [1:0] fi;
    int p;
    model(pats, outs, e, fv, fi, sq);
    @(negedge clk);
    start_v[s] = 1'b1;
    {in1, in0} = pats[1:0];
    dut_out = outs[0];
    @(negedge clk);
    start_v[s] = 1'b0;
    for (int c = 0; c < 4 * L; c++) begin
      p = c / L;
      {in1, in0} = pats[2*p +: 2];
      dut_out = outs[p];
      if (c == 0) chk_all(s, {tag, ".start"}, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0);
      if (mid_start) start_v[s] = (c == 5);
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_all(s, {tag, ".rst"}, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (c == 4 * L - 1) begin
        chk({tag, ".last_busy"}, {7'd0, busy_w[s]}, 8'd1);
        chk({tag, ".last_done"}, {7'd0, done_w[s]}, 8'd0);
      end
      @(negedge clk);
    end
    chk_all(s, {tag, ".end"}, 1'b0, 1'b1, (e == 3'd0) && !sq, e, fv, fi, sq);
  endtask

  localparam logic [7:0] ORDER = 8'b11_10_01_00;
  localparam logic [7:0] SWAP  = 8'b11_01_10_00;

  initial begin
    logic [7:0] pats;
    logic [3:0] outs;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++)
      chk_all(s, "reset", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;

    run("and250", 0, 250, ORDER, good_outs(ORDER), 1'b0, -1);
    run("or250",  0, 250, ORDER, 4'b1110, 1'b0, -1);
    run("restart250", 0, 250, ORDER, good_outs(ORDER), 1'b1, -1);
    run("order8", 1, 8, SWAP, good_outs(SWAP), 1'b0, -1);
    run("rst8",   1, 8, ORDER, good_outs(ORDER) ^ 4'b0001, 1'b0, 12);
    run("clean8", 1, 8, ORDER, good_outs(ORDER), 1'b0, -1);
    run("min2",   2, 2, ORDER, good_outs(ORDER), 1'b0, -1);

    for (int i = 0; i < 10; i++) begin
      pats = ORDER;
      if ($urandom_range(0, 1) == 1) pats = 8'($urandom);
      outs = good_outs(pats);
      for (int p = 0; p < 4; p++)
        if ($urandom_range(0, 3) == 0) outs[p] = ~outs[p];
      run("rand", 1 + (i % 2), (i % 2 == 0) ? 8 : 2, pats, outs, i[2], -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
